// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing arbiter: widths, ALU function codes, FSM encoding.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned SEL_W_DEF  = 3;

  // ALU function codes; 1xx yields RESULT=0 / ZERO=1 inside the ALU.
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Sequencer state encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention the port not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; last_i=1 means port 1 was served last, so port 0 has priority.
  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Sequencer sharing one external combinational ALU between two valid/ready requesters.
// Accept -> one settle cycle (EXEC) -> hold captured result until the owner takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [DATA_W-1:0] REQ0_DATA1,
  input  logic [DATA_W-1:0] REQ0_DATA2,
  input  logic [SEL_W-1:0]  REQ0_SELECT,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ1_DATA1,
  input  logic [DATA_W-1:0] REQ1_DATA2,
  input  logic [SEL_W-1:0]  REQ1_SELECT,
  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP_RESULT,
  output logic              RSP_ZERO,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [SEL_W-1:0]  ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic              ALU_ZERO,
  output logic              BUSY
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
  logic [SEL_W-1:0]  alu_select_q, alu_select_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic [1:0] gnt;
  logic       owner_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .req_i  ({REQ1_VALID, REQ0_VALID}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign owner_rsp_ready = owner_q ? RSP1_READY : RSP0_READY;

  // Next-state: accept in IDLE, capture ALU outputs after the settle cycle, release on response.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          alu_data1_d  = REQ1_DATA1;
          alu_data2_d  = REQ1_DATA2;
          alu_select_d = REQ1_SELECT;
          owner_d      = 1'b1;
          state_d      = EXEC;
        end else if (gnt[0]) begin
          alu_data1_d  = REQ0_DATA1;
          alu_data2_d  = REQ0_DATA2;
          alu_select_d = REQ0_SELECT;
          owner_d      = 1'b0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable for a full cycle, so its outputs have settled.
        rsp_result_d = ALU_RESULT;
        rsp_zero_d   = ALU_ZERO;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; pointer resets to 1 so port 0 wins the first contention.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // Handshake and status outputs.
  always_comb begin
    REQ0_READY = (state_q == IDLE) & gnt[0];
    REQ1_READY = (state_q == IDLE) & gnt[1];
    RSP0_VALID = (state_q == RESP) & ~owner_q;
    RSP1_VALID = (state_q == RESP) & owner_q;
    BUSY       = (state_q != IDLE);
  end

  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_SELECT = alu_select_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_ZERO   = rsp_zero_q;

endmodule
